// File: rtl/coriolis_ker1_subker1_ctrl.sv
// Run controller for the coriolis ker1/subker1 streaming datapath.
// Latency: 0-cycle combinational pass-through of valid/ready on both sides; state and counters registered.
// Backpressure: source is held off when the run quota is met or MAXINFLIGHT items are inside the kernel.
module coriolis_ker1_subker1_ctrl #(
  parameter int NW          = 20,
  parameter int MAXINFLIGHT = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [NW-1:0] ntot,
  output logic          busy,
  output logic          done,
  input  logic          src_valid,
  output logic          src_ready,
  output logic          ker_ivalid,
  input  logic          ker_iready,
  input  logic          ker_ovalid,
  output logic          ker_oready,
  output logic          snk_valid,
  input  logic          snk_ready,
  output logic [NW-1:0] in_cnt,
  output logic [NW-1:0] out_cnt
);

  // Run phases. DONE lasts exactly one cycle and is what produces the done pulse.
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  // Credit limit expressed at counter width so the compare stays NW bits wide.
  localparam logic [NW-1:0] MAX_IF = NW'(MAXINFLIGHT);
  localparam logic [NW-1:0] ONE    = NW'(1);

  logic [1:0]    state_q, state_d;
  logic [NW-1:0] ntot_q,  ntot_d;
  logic [NW-1:0] in_cnt_q,  in_cnt_d;
  logic [NW-1:0] out_cnt_q, out_cnt_d;

  logic          st_run;
  logic          st_drain;
  logic          st_active;
  logic [NW-1:0] inflight;
  logic          gate_in;
  logic          gate_out;
  logic          in_fire;
  logic          out_fire;
  logic          in_last;
  logic          out_last;

  assign st_run    = (state_q == S_RUN);
  assign st_drain  = (state_q == S_DRAIN);
  assign st_active = st_run | st_drain;

  // Items handed to the kernel but not yet passed to the sink. Results never
  // outnumber admitted items, so the subtraction cannot go negative.
  assign inflight = in_cnt_q - out_cnt_q;

  // Admission window: only while running, quota not met and credit available.
  assign gate_in  = st_run && (in_cnt_q < ntot_q) && (inflight < MAX_IF);

  // Result window: results keep flowing through RUN and DRAIN until the quota is met.
  assign gate_out = st_active && (out_cnt_q < ntot_q);

  // Each handshake side only looks at its own peer's signal plus the gate, so
  // src_valid never reaches ker_oready and snk_ready never reaches src_ready.
  assign ker_ivalid = src_valid  && gate_in;
  assign src_ready  = ker_iready && gate_in;
  assign snk_valid  = ker_ovalid && gate_out;
  assign ker_oready = snk_ready  && gate_out;

  assign in_fire  = src_valid  && ker_iready && gate_in;
  assign out_fire = ker_ovalid && snk_ready  && gate_out;

  // Gates guarantee cnt < ntot_q, so cnt+1 never wraps even for ntot = 2^NW-1.
  assign in_last  = in_fire  && ((in_cnt_q  + ONE) == ntot_q);
  assign out_last = out_fire && ((out_cnt_q + ONE) == ntot_q);

  assign busy    = st_active;
  assign done    = (state_q == S_DONE);
  assign in_cnt  = in_cnt_q;
  assign out_cnt = out_cnt_q;

  // Next-state, quota latch and beat counting for the current run.
  always_comb begin
    state_d   = state_q;
    ntot_d    = ntot_q;
    in_cnt_d  = in_cnt_q;
    out_cnt_d = out_cnt_q;

    if (in_fire) begin
      in_cnt_d = in_cnt_q + ONE;
    end
    if (out_fire) begin
      out_cnt_d = out_cnt_q + ONE;
    end

    case (state_q)
      S_IDLE: begin
        // Counters keep the previous run's totals until a new start arrives.
        if (start) begin
          in_cnt_d  = '0;
          out_cnt_d = '0;
          if (ntot != '0) begin
            ntot_d  = ntot;
            state_d = S_RUN;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_RUN: begin
        // Output can only complete alongside the final admission if the kernel
        // had nothing left in flight, so both are tested on the same beat.
        if (in_last) begin
          state_d = (out_cnt_d == ntot_q) ? S_DONE : S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (out_last) begin
          state_d = S_DONE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Registered state; reset abandons any run in progress without a done pulse.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      ntot_q    <= '0;
      in_cnt_q  <= '0;
      out_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      ntot_q    <= ntot_d;
      in_cnt_q  <= in_cnt_d;
      out_cnt_q <= out_cnt_d;
    end
  end

  // Credit limit must hold whenever the block is out of reset.
  a_inflight_bound : assert property (@(posedge clk) disable iff (!rst)
    (inflight <= MAX_IF));

  // Admission and delivery never overshoot the latched quota during a run.
  a_quota_bound : assert property (@(posedge clk) disable iff (!rst)
    (st_active |-> (in_cnt_q <= ntot_q) && (out_cnt_q <= ntot_q)));

endmodule

// File: tb/tb_coriolis_ker1_subker1_ctrl.sv
// Bench for the coriolis ker1/subker1 run controller.
// Drives randomized source/kernel/sink handshakes around a queue-based kernel model.
// Expected outputs come from a per-cycle behavioural model of the run rules.
module tb_coriolis_ker1_subker1_ctrl;

  localparam int NW   = 20;
  localparam int MAXI = 4;

  localparam int P_IDLE  = 0;
  localparam int P_RUN   = 1;
  localparam int P_DRAIN = 2;
  localparam int P_DONE  = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [NW-1:0] ntot;
  logic          busy;
  logic          done;
  logic          src_valid;
  logic          src_ready;
  logic          ker_ivalid;
  logic          ker_iready;
  logic          ker_ovalid;
  logic          ker_oready;
  logic          snk_valid;
  logic          snk_ready;
  logic [NW-1:0] in_cnt;
  logic [NW-1:0] out_cnt;

  coriolis_ker1_subker1_ctrl #(.NW(NW), .MAXINFLIGHT(MAXI)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .ntot       (ntot),
    .busy       (busy),
    .done       (done),
    .src_valid  (src_valid),
    .src_ready  (src_ready),
    .ker_ivalid (ker_ivalid),
    .ker_iready (ker_iready),
    .ker_ovalid (ker_ovalid),
    .ker_oready (ker_oready),
    .snk_valid  (snk_valid),
    .snk_ready  (snk_ready),
    .in_cnt     (in_cnt),
    .out_cnt    (out_cnt)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Behavioural model of one run: phase, admitted, delivered, quota.
  int m_ph   = P_IDLE;
  int m_in   = 0;
  int m_out  = 0;
  int m_ntot = 0;
  int now    = 0;
  int done_seen = 0;

  // Kernel model: each entry is the cycle at which that result becomes visible.
  int kq[$];
  int lat   = 3;
  int pv_src = 100;
  int pv_ir  = 100;
  int pv_sr  = 100;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s t=%0t got=%0h exp=%0h", tag, $time, got, exp);
    end
  endtask

  // One clock: randomize handshakes, compare against the model, advance both.
  task automatic tick();
    bit e_gin, e_gout, e_in_fire, e_out_fire;
    src_valid  = ($urandom_range(99) < pv_src);
    ker_iready = ($urandom_range(99) < pv_ir);
    snk_ready  = ($urandom_range(99) < pv_sr);
    ker_ovalid = (kq.size() > 0) && (kq[0] <= now);
    #1;
    e_gin  = (m_ph == P_RUN) && (m_in < m_ntot) && ((m_in - m_out) < MAXI);
    e_gout = ((m_ph == P_RUN) || (m_ph == P_DRAIN)) && (m_out < m_ntot);
    chk("busy",       32'(busy),       32'((m_ph == P_RUN) || (m_ph == P_DRAIN)));
    chk("done",       32'(done),       32'(m_ph == P_DONE));
    chk("ker_ivalid", 32'(ker_ivalid), 32'(src_valid && e_gin));
    chk("src_ready",  32'(src_ready),  32'(ker_iready && e_gin));
    chk("snk_valid",  32'(snk_valid),  32'(ker_ovalid && e_gout));
    chk("ker_oready", 32'(ker_oready), 32'(snk_ready && e_gout));
    chk("in_cnt",     32'(in_cnt),     32'(m_in));
    chk("out_cnt",    32'(out_cnt),    32'(m_out));
    if (m_ph == P_DONE) done_seen++;
    e_in_fire  = src_valid && ker_iready && e_gin;
    e_out_fire = ker_ovalid && snk_ready && e_gout;
    @(posedge clk);
    if (!rst) begin
      m_ph = P_IDLE; m_in = 0; m_out = 0; m_ntot = 0;
      kq.delete();
    end else begin
      if (e_in_fire)  kq.push_back(now + lat);
      if (e_out_fire) void'(kq.pop_front());
      case (m_ph)
        P_IDLE: if (start) begin
          m_in = 0; m_out = 0;
          if (ntot == 0) m_ph = P_DONE;
          else begin m_ntot = int'(ntot); m_ph = P_RUN; end
        end
        P_RUN: begin
          if (e_in_fire)  m_in++;
          if (e_out_fire) m_out++;
          if (m_in == m_ntot) m_ph = (m_out == m_ntot) ? P_DONE : P_DRAIN;
        end
        P_DRAIN: begin
          if (e_out_fire) m_out++;
          if (m_out == m_ntot) m_ph = P_DONE;
        end
        default: m_ph = P_IDLE;
      endcase
    end
    now++;
    #1;
  endtask

  // Pulse start for one cycle, then clock until the model is back in IDLE.
  task automatic do_run(input string tag, input int n, input int bound);
    int k;
    done_seen = 0;
    ntot  = NW'(n);
    start = 1'b1;
    tick();
    start = 1'b0;
    k = 0;
    while (m_ph != P_IDLE && k < bound) begin
      tick();
      k++;
    end
    chk({tag, "_timeout"}, 32'(m_ph == P_IDLE), 32'd1);
    chk({tag, "_done_cnt"}, 32'(done_seen), 32'd1);
  endtask

  initial begin
    int k;
    rst = 1'b0; start = 1'b0; ntot = '0;
    src_valid = 1'b0; ker_iready = 1'b0; ker_ovalid = 1'b0; snk_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    // Reset state, with all inputs active to prove nothing leaks through.
    src_valid = 1'b1; ker_iready = 1'b1; ker_ovalid = 1'b1; snk_ready = 1'b1; start = 1'b1;
    #1;
    chk("rst_busy",  32'(busy), 32'd0);
    chk("rst_done",  32'(done), 32'd0);
    chk("rst_srdy",  32'(src_ready), 32'd0);
    chk("rst_kiv",   32'(ker_ivalid), 32'd0);
    chk("rst_kor",   32'(ker_oready), 32'd0);
    chk("rst_snkv",  32'(snk_valid), 32'd0);
    chk("rst_incnt", 32'(in_cnt), 32'd0);
    chk("rst_outcnt",32'(out_cnt), 32'd0);
    start = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;

    // T1: full throughput, latency 3.
    lat = 3; pv_src = 100; pv_ir = 100; pv_sr = 100;
    do_run("t1", 4, 200);
    chk("t1_in_final",  32'(in_cnt),  32'd4);
    chk("t1_out_final", 32'(out_cnt), 32'd4);

    // T2: zero-length run, done on the second edge, nothing ever admitted.
    do_run("t2", 0, 20);
    chk("t2_in_final", 32'(in_cnt), 32'd0);

    // T3: sink stalled; credit limit stops admission at MAXI.
    pv_sr = 0;
    ntot = NW'(10); start = 1'b1; tick(); start = 1'b0;
    repeat (30) tick();
    chk("t3_in_stall", 32'(in_cnt), 32'(MAXI));
    chk("t3_srdy_low", 32'(src_ready), 32'd0);
    pv_sr = 100;
    done_seen = 0;
    k = 0;
    while (m_ph != P_IDLE && k < 200) begin tick(); k++; end
    chk("t3_timeout", 32'(m_ph == P_IDLE), 32'd1);
    chk("t3_done_cnt", 32'(done_seen), 32'd1);
    chk("t3_out_final", 32'(out_cnt), 32'd10);

    // T4: steady firing with latency 2.
    lat = 2;
    do_run("t4", 8, 200);
    chk("t4_out_final", 32'(out_cnt), 32'd8);

    // T5: start held high with a changed ntot during the run is ignored.
    lat = 3;
    done_seen = 0;
    ntot = NW'(7); start = 1'b1; tick();
    ntot = NW'(99);
    k = 0;
    while (m_ph != P_IDLE && k < 300) begin
      if (m_ph == P_DONE) start = 1'b0;
      tick();
      k++;
    end
    start = 1'b0;
    chk("t5_timeout", 32'(m_ph == P_IDLE), 32'd1);
    chk("t5_done_cnt", 32'(done_seen), 32'd1);
    chk("t5_out_final", 32'(out_cnt), 32'd7);

    // T6: reset while draining, then a clean two-item run.
    pv_sr = 20;
    ntot = NW'(6); start = 1'b1; tick(); start = 1'b0;
    k = 0;
    while (m_ph != P_DRAIN && k < 300) begin tick(); k++; end
    chk("t6_reach_drain", 32'(m_ph), 32'(P_DRAIN));
    rst = 1'b0; tick(); rst = 1'b1;
    done_seen = 0;
    repeat (3) tick();
    chk("t6_no_done", 32'(done_seen), 32'd0);
    pv_sr = 100;
    do_run("t6b", 2, 100);

    // Randomized runs across handshake densities and kernel latencies.
    for (int r = 0; r < 25; r++) begin
      lat    = $urandom_range(5, 1);
      pv_src = $urandom_range(100, 30);
      pv_ir  = $urandom_range(100, 30);
      pv_sr  = $urandom_range(100, 20);
      do_run("rnd", (r % 7 == 6) ? 0 : $urandom_range(40, 1), 2000);
      repeat ($urandom_range(3)) tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
